mem_bus_ctrl: RTL and testbench
===============================

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 Parameter RAM_WORDS, default 256: number of 16-bit RAM words.
REQ-002 Parameter LED_ADDR, default 9'h100: memory-mapped LED register address.
REQ-003 Parameter SW_ADDR, default 9'h140: memory-mapped switch input address.
REQ-004 Port clk, input, 1: single clock; all state SHALL change on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-low reset; 0 = reset asserted.
REQ-006 Port mem_cmd, input, 2: requester command; NONE=00, READ=01, WRITE=10, 11 illegal.
REQ-007 Port mem_addr, input, 9: word address of the request.
REQ-008 Port write_data, input, 16: store data, sampled with a WRITE.
REQ-009 Port sw, input, 8: switch inputs.
REQ-010 Port read_data, output, 16: registered load data.
REQ-011 Port mem_ready, output, 1: one-cycle completion strobe.
REQ-012 Port led, output, 8: registered LED outputs.
REQ-013 Port err, output, 1: sticky error flag.
REQ-014 Port txn_count, output, 16: completed-transaction counter.

Function
REQ-015 Address map SHALL be: RAM for mem_addr[8]==0 (0x000-0x0FF), LED_ADDR (write-only), SW_ADDR (read-only); every other address is unmapped.
REQ-016 FSM states SHALL be IDLE, RD_WAIT, ACK.
REQ-017 Transitions: IDLE+READ -> RD_WAIT; IDLE+WRITE -> ACK; IDLE+NONE/illegal -> IDLE; RD_WAIT -> ACK; ACK -> IDLE.
REQ-018 Commands SHALL be sampled only in IDLE; mem_cmd in RD_WAIT and ACK SHALL be ignored.
REQ-019 The requester holds mem_cmd, mem_addr, and write_data stable until it sees mem_ready.
REQ-020 RAM write SHALL occur on the IDLE->ACK edge.
REQ-021 LED write SHALL load led <= write_data[7:0] on the same edge.
REQ-022 RAM read SHALL present the address in IDLE and capture data into read_data on the RD_WAIT->ACK edge; read latency is exactly 2 cycles from command to mem_ready.
REQ-023 A read of SW_ADDR SHALL return {8'h00, sw} sampled on the RD_WAIT->ACK edge.
REQ-024 mem_ready SHALL be 1 exactly while in ACK.
REQ-025 read_data SHALL hold its value until the next read ACK; writes SHALL NOT alter it.
REQ-026 An unmapped read, a write to SW_ADDR, or a read of LED_ADDR SHALL complete normally: read returns 16'h0000, write is dropped, err is set to 1.
REQ-027 An illegal command (11) in IDLE SHALL set err, produce no ACK, and remain in IDLE.
REQ-028 err SHALL stay 1 until reset.
REQ-029 txn_count SHALL increment by 1 on each ACK, wrapping from 16'hFFFF to 0.
REQ-030 Back-to-back requests: a command present in the IDLE cycle following ACK SHALL be accepted; maximum throughput is one write per 2 cycles or one read per 3 cycles.

Reset
REQ-031 While reset==0: state=IDLE, read_data=0, mem_ready=0, led=0, err=0, txn_count=0, asynchronously.
REQ-032 Reset asserted mid-transaction SHALL abort it with no ACK; a pending write not yet on its edge SHALL NOT occur.
REQ-033 RAM contents SHALL NOT be cleared by reset.

Structure
REQ-034 Package mem_pkg SHALL hold the command encodings (NONE, READ, WRITE), FSM state enum, and default address constants.
REQ-035 Sub-module ram_sync SHALL implement single-port synchronous RAM (RAM_WORDS x 16, 1-cycle registered read, write-enable).

Verification
REQ-036 WRITE 16'h00A5 to 0x010, then READ 0x010 -> mem_ready 1 cycle after write; on read, mem_ready 2 cycles later with read_data=16'h00A5.
REQ-037 WRITE 16'h1234 to 0x100 -> led=8'h34, err=0, read_data unchanged.
REQ-038 sw=8'h5A, READ 0x140 -> read_data=16'h005A at mem_ready.
REQ-039 READ 0x1F0 -> read_data=16'h0000, err=1; then mem_cmd=11 in IDLE -> no mem_ready, err stays 1.
REQ-040 reset=0 during RD_WAIT -> mem_ready never pulses, read_data=0, txn_count=0; a subsequent READ of a previously written word returns that word.
REQ-041 Preload txn_count to 16'hFFFF via 65535 writes, then one more write -> txn_count=0.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory-bus controller.
//   - requester command encodings (2'b11 is illegal)
//   - controller FSM state type
//   - read-source select used to remember what a pending read returns
//   - default memory-map addresses for the LED and switch registers
package mem_pkg;

  localparam logic [1:0] CmdNone  = 2'b00;
  localparam logic [1:0] CmdRead  = 2'b01;
  localparam logic [1:0] CmdWrite = 2'b10;
  localparam logic [1:0] CmdIll   = 2'b11;

  localparam logic [8:0] DefLedAddr = 9'h100;
  localparam logic [8:0] DefSwAddr  = 9'h140;

  typedef enum logic [1:0] {
    StIdle,
    StRdWait,
    StAck
  } state_e;

  typedef enum logic [1:0] {
    SelRam,
    SelSw,
    SelZero
  } rd_sel_e;

endpackage

// File: rtl/ram_sync.sv
// ram_sync: single-port synchronous RAM, Words x 16, registered read.
// Ports:
//   clk    - clock
//   we     - write enable; wdata is stored at addr on the rising edge
//   addr   - word address
//   wdata  - write data
//   rdata  - data at addr as of the previous rising edge (read-before-write)
// Contents are deliberately not reset.
module ram_sync #(
  parameter int unsigned Words = 256,
  parameter int unsigned AddrW = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AddrW-1:0] addr,
  input  logic [15:0]      wdata,
  output logic [15:0]      rdata
);

  logic [15:0] mem_q [Words];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata <= mem_q[addr];
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: memory-mapped bus controller with RAM, an LED register and
// a switch input port.
// Ports:
//   clk         - clock, all state changes on its rising edge
//   reset       - asynchronous active-low reset
//   mem_cmd     - NONE/READ/WRITE request (11 is illegal and flags err)
//   mem_addr    - word address; held stable by the requester until mem_ready
//   write_data  - store data for WRITE
//   sw          - switch inputs, readable at SW_ADDR
//   read_data   - registered load data, only updated by a read completion
//   mem_ready   - one-cycle completion strobe (high exactly in ACK)
//   led         - registered LED outputs, written at LED_ADDR
//   err         - sticky error flag, cleared only by reset
//   txn_count   - completed-transaction counter, wraps at 16 bits
// Writes complete one cycle after the command, reads two cycles after.
module mem_bus_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned RAM_WORDS = 256,
  parameter logic [8:0]  LED_ADDR  = DefLedAddr,
  parameter logic [8:0]  SW_ADDR   = DefSwAddr
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mem_cmd,
  input  logic [8:0]  mem_addr,
  input  logic [15:0] write_data,
  input  logic [7:0]  sw,
  output logic [15:0] read_data,
  output logic        mem_ready,
  output logic [7:0]  led,
  output logic        err,
  output logic [15:0] txn_count
);

  state_e      state_q;
  rd_sel_e     rd_sel_q;
  logic [15:0] read_data_q;
  logic        mem_ready_q;
  logic [7:0]  led_q;
  logic        err_q;
  logic [15:0] txn_count_q;

  logic        is_ram;
  logic        is_led;
  logic        is_sw;
  logic        ram_we;
  logic [15:0] ram_rdata;

  // Address decode of the (stable) request address.
  always_comb begin
    is_ram = (mem_addr[8] == 1'b0) && ({23'd0, mem_addr} < RAM_WORDS);
    is_led = (mem_addr == LED_ADDR);
    is_sw  = (mem_addr == SW_ADDR);
  end

  // Gated by reset so a write pending in IDLE never lands while reset is held.
  assign ram_we = reset && (state_q == StIdle) && (mem_cmd == CmdWrite) && is_ram;

  ram_sync #(
    .Words (RAM_WORDS),
    .AddrW (8)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (mem_addr[7:0]),
    .wdata (write_data),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      rd_sel_q    <= SelZero;
      read_data_q <= 16'h0000;
      mem_ready_q <= 1'b0;
      led_q       <= 8'h00;
      err_q       <= 1'b0;
      txn_count_q <= 16'h0000;
    end else begin
      mem_ready_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          case (mem_cmd)
            CmdRead: begin
              state_q <= StRdWait;
              if (is_ram) begin
                rd_sel_q <= SelRam;
              end else if (is_sw) begin
                rd_sel_q <= SelSw;
              end else begin
                // Unmapped or LED_ADDR: complete with zero data.
                rd_sel_q <= SelZero;
                err_q    <= 1'b1;
              end
            end
            CmdWrite: begin
              state_q     <= StAck;
              mem_ready_q <= 1'b1;
              txn_count_q <= txn_count_q + 16'd1;
              if (is_led) begin
                led_q <= write_data[7:0];
              end else if (!is_ram) begin
                // SW_ADDR or unmapped: drop the write.
                err_q <= 1'b1;
              end
            end
            CmdIll: begin
              err_q <= 1'b1;
            end
            default: begin
            end
          endcase
        end
        StRdWait: begin
          state_q     <= StAck;
          mem_ready_q <= 1'b1;
          txn_count_q <= txn_count_q + 16'd1;
          unique case (rd_sel_q)
            SelRam:  read_data_q <= ram_rdata;
            SelSw:   read_data_q <= {8'h00, sw};
            default: read_data_q <= 16'h0000;
          endcase
        end
        StAck: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign read_data = read_data_q;
  assign mem_ready = mem_ready_q;
  assign led       = led_q;
  assign err       = err_q;
  assign txn_count = txn_count_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: a table of transactions with their
// expected completion latency and outputs, a scoreboard queue of expected
// results, and hand-written sequences for reset, illegal-command,
// back-to-back and counter-wrap corners.
module tb_mem_bus_ctrl;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [7:0]  sw;
  logic [15:0] read_data;
  logic        mem_ready;
  logic [7:0]  led;
  logic        err;
  logic [15:0] txn_count;

  always #5 clk = ~clk;

  mem_bus_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .mem_cmd    (mem_cmd),
    .mem_addr   (mem_addr),
    .write_data (write_data),
    .sw         (sw),
    .read_data  (read_data),
    .mem_ready  (mem_ready),
    .led        (led),
    .err        (err),
    .txn_count  (txn_count)
  );

  typedef struct {
    logic [1:0]  cmd;
    logic [8:0]  addr;
    logic [15:0] wdata;
    logic [7:0]  sw;
    int          lat;
    logic [15:0] rdata;
    logic [7:0]  led;
    logic        err;
    logic [15:0] txn;
  } vec_t;

  vec_t vecs[8];
  vec_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic vec_t mk(input logic [1:0] cmd, input logic [8:0] addr,
                              input logic [15:0] wdata, input logic [7:0] swv, input int lat,
                              input logic [15:0] rdata, input logic [7:0] ledv,
                              input logic errv, input logic [15:0] txn);
    vec_t v;
    v.cmd = cmd; v.addr = addr; v.wdata = wdata; v.sw = swv; v.lat = lat;
    v.rdata = rdata; v.led = ledv; v.err = errv; v.txn = txn;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Drive one transaction from IDLE, wait (bounded) for mem_ready, compare
  // against the scoreboard entry, then return to IDLE.
  task automatic run_txn(input string tag, input vec_t v);
    vec_t e;
    int   lat;
    bit   got;
    sb_q.push_back(v);
    sw         = v.sw;
    mem_cmd    = v.cmd;
    mem_addr   = v.addr;
    write_data = v.wdata;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      if (mem_ready) got = 1'b1;
    end
    e = sb_q.pop_front();
    if (!got) begin
      chk({tag, " ready timeout"}, 32'(mem_ready), 32'd1);
    end else begin
      chk({tag, " latency"}, 32'(lat), 32'(e.lat));
      chk({tag, " read_data"}, 32'(read_data), 32'(e.rdata));
      chk({tag, " led"}, 32'(led), 32'(e.led));
      chk({tag, " err"}, 32'(err), 32'(e.err));
      chk({tag, " txn_count"}, 32'(txn_count), 32'(e.txn));
    end
    mem_cmd = CmdNone;
    @(posedge clk); #1;
    chk({tag, " ready one cycle"}, 32'(mem_ready), 32'd0);
  endtask

  task automatic do_reset();
    mem_cmd = CmdNone;
    @(negedge clk); reset = 1'b0;
    @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    bit saw_ready;

    vecs[0] = mk(CmdWrite, 9'h010, 16'h00A5, 8'h00, 1, 16'h0000, 8'h00, 1'b0, 16'd1);
    vecs[1] = mk(CmdRead,  9'h010, 16'h0000, 8'h00, 2, 16'h00A5, 8'h00, 1'b0, 16'd2);
    vecs[2] = mk(CmdWrite, 9'h100, 16'h1234, 8'h00, 1, 16'h00A5, 8'h34, 1'b0, 16'd3);
    vecs[3] = mk(CmdRead,  9'h140, 16'h0000, 8'h5A, 2, 16'h005A, 8'h34, 1'b0, 16'd4);
    vecs[4] = mk(CmdWrite, 9'h0FF, 16'hBEEF, 8'h5A, 1, 16'h005A, 8'h34, 1'b0, 16'd5);
    vecs[5] = mk(CmdRead,  9'h0FF, 16'h0000, 8'h00, 2, 16'hBEEF, 8'h34, 1'b0, 16'd6);
    vecs[6] = mk(CmdRead,  9'h010, 16'h0000, 8'h00, 2, 16'h00A5, 8'h34, 1'b0, 16'd7);
    vecs[7] = mk(CmdRead,  9'h1F0, 16'h0000, 8'h00, 2, 16'h0000, 8'h34, 1'b1, 16'd8);

    reset = 1'b0; mem_cmd = CmdNone; mem_addr = '0; write_data = '0; sw = '0;
    #2;
    chk("reset read_data", 32'(read_data), 32'd0);
    chk("reset mem_ready", 32'(mem_ready), 32'd0);
    chk("reset led", 32'(led), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset txn_count", 32'(txn_count), 32'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_txn($sformatf("vec%0d", i), vecs[i]);

    // Illegal command in IDLE: no completion, err stays set.
    mem_cmd = CmdIll; mem_addr = 9'h010;
    saw_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (mem_ready) saw_ready = 1'b1;
    end
    chk("illegal no ready", 32'(saw_ready), 32'd0);
    chk("illegal err", 32'(err), 32'd1);
    chk("illegal txn_count", 32'(txn_count), 32'd8);
    mem_cmd = CmdNone;
    @(posedge clk); #1;

    // Reset during RD_WAIT aborts the read asynchronously.
    mem_cmd = CmdRead; mem_addr = 9'h010;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("abort rd read_data", 32'(read_data), 32'd0);
    chk("abort rd txn_count", 32'(txn_count), 32'd0);
    chk("abort rd err", 32'(err), 32'd0);
    chk("abort rd led", 32'(led), 32'd0);
    saw_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (mem_ready) saw_ready = 1'b1;
    end
    chk("abort rd no ready", 32'(saw_ready), 32'd0);
    mem_cmd = CmdNone;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    run_txn("ram kept", mk(CmdRead, 9'h010, 16'h0, 8'h0, 2, 16'h00A5, 8'h00, 1'b0, 16'd1));

    // Reset before the IDLE->ACK edge drops the pending write.
    run_txn("pre wr", mk(CmdWrite, 9'h030, 16'h2222, 8'h0, 1, 16'h00A5, 8'h00, 1'b0, 16'd2));
    mem_cmd = CmdWrite; mem_addr = 9'h030; write_data = 16'h1111;
    #2 reset = 1'b0;
    @(posedge clk); #1;
    mem_cmd = CmdNone;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    run_txn("wr dropped", mk(CmdRead, 9'h030, 16'h0, 8'h0, 2, 16'h2222, 8'h00, 1'b0, 16'd1));

    // Illegal-address accesses complete but flag err.
    run_txn("wr sw", mk(CmdWrite, 9'h140, 16'h5555, 8'h0, 1, 16'h2222, 8'h00, 1'b1, 16'd2));
    run_txn("rd led", mk(CmdRead, 9'h100, 16'h0, 8'h0, 2, 16'h0000, 8'h00, 1'b1, 16'd3));
    do_reset();
    run_txn("rd led fresh", mk(CmdRead, 9'h100, 16'h0, 8'h0, 2, 16'h0000, 8'h00, 1'b1, 16'd1));

    // Back-to-back writes: next command held through ACK, taken in next IDLE.
    do_reset();
    mem_cmd = CmdWrite; mem_addr = 9'h040; write_data = 16'h0101;
    @(posedge clk); #1;
    chk("b2b ack1", 32'(mem_ready), 32'd1);
    mem_addr = 9'h041; write_data = 16'h0202;
    @(posedge clk); #1;
    chk("b2b idle", 32'(mem_ready), 32'd0);
    @(posedge clk); #1;
    chk("b2b ack2", 32'(mem_ready), 32'd1);
    chk("b2b txn_count", 32'(txn_count), 32'd2);
    mem_cmd = CmdNone;
    @(posedge clk); #1;
    run_txn("b2b rd0", mk(CmdRead, 9'h040, 16'h0, 8'h0, 2, 16'h0101, 8'h00, 1'b0, 16'd3));
    run_txn("b2b rd1", mk(CmdRead, 9'h041, 16'h0, 8'h0, 2, 16'h0202, 8'h00, 1'b0, 16'd4));

    // Counter wrap: preload the counter instead of issuing 65535 writes.
    do_reset();
    dut.txn_count_q = 16'hFFFF;
    run_txn("wrap wr", mk(CmdWrite, 9'h050, 16'h0ABC, 8'h0, 1, 16'h0000, 8'h00, 1'b0, 16'd0));
    run_txn("wrap rd", mk(CmdRead, 9'h050, 16'h0, 8'h0, 2, 16'h0ABC, 8'h00, 1'b0, 16'd1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
